soi_tracer: RTL and testbench

Hardware-side observer for a signal of interest (SOI). It samples the SOI every clock, turns value changes into timestamped event entries, buffers them in a small FIFO, and presents them on a valid/ready read port drained by the host-side reader. It is the read/observe counterpart of the host-driven set/get path: software forces and polls SOI values through that path, and pulls the SOI's change history through this block.

---
 rtl/soi_trace_pkg.sv | 16 +
 rtl/soi_trace_fifo.sv | 64 ++++++
 rtl/soi_tracer.sv | 84 ++++++++
 tb/tb_soi_tracer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/soi_trace_pkg.sv
// Shared types and constants for the SOI change tracer.
// soi_entry_t and TS_MAX describe the default-width configuration.
package soi_trace_pkg;

  localparam int SOI_W_DEF = 8;
  localparam int TS_W_DEF  = 16;

  typedef struct packed {
    logic                wrap;
    logic [TS_W_DEF-1:0]  ts;
    logic [SOI_W_DEF-1:0] value;
  } soi_entry_t;

  localparam logic [TS_W_DEF-1:0] TS_MAX = '1;

endpackage

// File: rtl/soi_trace_fifo.sv
// First-word-fall-through FIFO for trace entries.
// A push into a full FIFO is still taken when the head is popped in the same cycle.
module soi_trace_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         accepted
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  // Storage is deliberately left out of reset; only pointers and level are cleared.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic          pop;

  assign rd_valid = (level_reg != '0);
  assign pop      = rd_valid & rd_ready;
  assign accepted = push & ((level_reg < LW'(DEPTH)) | pop);
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
  assign level    = level_reg;

  always_comb begin
    wr_ptr_next = accepted ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    level_next  = level_reg;
    case ({accepted, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/soi_tracer.sv
// Observes a signal every clock and queues timestamped change/sync/wrap entries
// for a valid/ready reader; entries that find the FIFO full are counted as drops.
module soi_tracer
  import soi_trace_pkg::*;
#(
  parameter int SOI_W  = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SOI_W-1:0]            soi_i,
  input  logic                        enable_i,
  input  logic                        drop_clr_i,
  output logic                        rd_valid_o,
  input  logic                        rd_ready_i,
  output logic [TS_W+SOI_W:0]         rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]  level_o,
  output logic [DROP_W-1:0]           drop_cnt_o
);

  localparam int ENTRY_W = 1 + TS_W + SOI_W;
  localparam logic [TS_W-1:0]   TS_ALL_ONES = '1;
  localparam logic [DROP_W-1:0] DROP_SAT    = '1;

  logic [TS_W-1:0]   ts_reg;
  logic [SOI_W-1:0]  prev_reg;
  logic              en_reg;
  logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic               wrap;
  logic               push_req;
  logic               accepted;
  logic               drop;
  logic [ENTRY_W-1:0] entry;

  // First enabled cycle, a value change, or a timestamp rollover all emit one entry.
  assign wrap     = (ts_reg == TS_ALL_ONES);
  assign push_req = enable_i & (~en_reg | (soi_i != prev_reg) | wrap);
  assign entry    = {wrap, ts_reg, soi_i};
  assign drop     = push_req & ~accepted;

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (drop_clr_i) begin
      drop_cnt_next = '0;
    end else if (drop && (drop_cnt_reg != DROP_SAT)) begin
      drop_cnt_next = drop_cnt_reg + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_reg       <= '0;
      prev_reg     <= '0;
      en_reg       <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      ts_reg       <= ts_reg + TS_W'(1);
      prev_reg     <= soi_i;
      en_reg       <= enable_i;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign drop_cnt_o = drop_cnt_reg;

  soi_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (entry),
    .rd_ready  (rd_ready_i),
    .rd_valid  (rd_valid_o),
    .rd_data   (rd_data_o),
    .level     (level_o),
    .accepted  (accepted)
  );

endmodule

// File: tb/tb_soi_tracer.sv
// Directed bench for soi_tracer: a default-width instance plus a TS_W=4 instance
// used to reach timestamp rollover quickly.
module tb_soi_tracer;
  import soi_trace_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  soi_a, soi_b;
  logic        en_a, en_b, clr_a, clr_b, rdy_a, rdy_b;
  logic        valid_a, valid_b;
  logic [24:0] data_a;
  logic [12:0] data_b;
  logic [3:0]  level_a, level_b;
  logic [7:0]  drop_a, drop_b;

  soi_tracer dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .soi_i      (soi_a),
    .enable_i   (en_a),
    .drop_clr_i (clr_a),
    .rd_valid_o (valid_a),
    .rd_ready_i (rdy_a),
    .rd_data_o  (data_a),
    .level_o    (level_a),
    .drop_cnt_o (drop_a)
  );

  soi_tracer #(.TS_W(4)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .soi_i      (soi_b),
    .enable_i   (en_b),
    .drop_clr_i (clr_b),
    .rd_valid_o (valid_b),
    .rd_ready_i (rdy_b),
    .rd_data_o  (data_b),
    .level_o    (level_b),
    .drop_cnt_o (drop_b)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  logic [15:0] t1;
  logic [15:0] qts[$];
  logic [7:0]  qv[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [24:0] ea(input logic w, input logic [15:0] ts, input logic [7:0] v);
    soi_entry_t e;
    e.wrap  = w;
    e.ts    = ts;
    e.value = v;
    return e;
  endfunction

  function automatic logic [12:0] eb(input logic w, input logic [3:0] ts, input logic [7:0] v);
    return {w, ts, v};
  endfunction

  initial begin
    rst_n = 1'b0;
    soi_a = 8'h00; soi_b = 8'h00;
    en_a = 1'b0; en_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_a), 32'(0));
    chk("rst_level", 32'(level_a), 32'(0));
    chk("rst_data", 32'(data_a), 32'(0));
    chk("rst_drop", 32'(drop_a), 32'(0));
    rst_n = 1'b1;
    cyc = 0;

    // sync entry on first enabled cycle, then silence while soi is constant
    step(); step();
    en_a = 1'b1;
    step();
    chk("sync_valid", 32'(valid_a), 32'(1));
    chk("sync_level", 32'(level_a), 32'(1));
    chk("sync_data", 32'(data_a), 32'(ea(1'b0, 16'd2, 8'h00)));
    step(); step(); step();
    chk("sync_quiet", 32'(level_a), 32'(1));
    rdy_a = 1'b1;
    step();
    chk("sync_pop_level", 32'(level_a), 32'(0));
    chk("sync_pop_valid", 32'(valid_a), 32'(0));
    chk("empty_data", 32'(data_a), 32'(0));

    // back-to-back changes with the reader always ready
    soi_a = 8'h5A; t1 = 16'(cyc);
    step();
    chk("chg1_data", 32'(data_a), 32'(ea(1'b0, t1, 8'h5A)));
    chk("chg1_level", 32'(level_a), 32'(1));
    soi_a = 8'hA5;
    step();
    chk("chg2_data", 32'(data_a), 32'(ea(1'b0, t1 + 16'd1, 8'hA5)));
    chk("chg2_level", 32'(level_a), 32'(1));
    step();
    chk("chg_drain", 32'(level_a), 32'(0));

    // overflow: 10 changes into an 8-deep FIFO with no reader
    rdy_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      soi_a = 8'(i);
      if (i <= 8) begin
        qts.push_back(16'(cyc));
        qv.push_back(8'(i));
      end
      step();
    end
    chk("ovf_level", 32'(level_a), 32'(8));
    chk("ovf_drop", 32'(drop_a), 32'(2));
    rdy_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_read", 32'(data_a), 32'(ea(1'b0, qts[0], qv[0])));
      void'(qts.pop_front());
      void'(qv.pop_front());
      step();
    end
    chk("ovf_empty", 32'(level_a), 32'(0));

    // full FIFO with simultaneous push and pop each cycle
    rdy_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      soi_a = 8'h20 + 8'(i);
      qts.push_back(16'(cyc));
      qv.push_back(soi_a);
      step();
    end
    chk("full_level", 32'(level_a), 32'(8));
    rdy_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      soi_a = 8'h30 + 8'(k);
      chk("full_head", 32'(data_a), 32'(ea(1'b0, qts[0], qv[0])));
      void'(qts.pop_front());
      void'(qv.pop_front());
      qts.push_back(16'(cyc));
      qv.push_back(soi_a);
      step();
      chk("full_pp_level", 32'(level_a), 32'(8));
      chk("full_pp_drop", 32'(drop_a), 32'(2));
    end
    rdy_a = 1'b0;
    soi_a = 8'h40; clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("clr_wins", 32'(drop_a), 32'(0));
    soi_a = 8'h41;
    step();
    chk("drop_after_clr", 32'(drop_a), 32'(1));
    rdy_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("full_drain", 32'(data_a), 32'(ea(1'b0, qts[0], qv[0])));
      void'(qts.pop_front());
      void'(qv.pop_front());
      step();
    end
    chk("full_empty", 32'(level_a), 32'(0));
    rdy_a = 1'b0;

    // TS_W=4 instance: wrap markers at ts=F, change at ts=F merges into one entry
    soi_b = 8'h3C;
    while ((cyc % 16) != 3) step();
    en_b = 1'b1;
    step();
    while ((cyc % 16) != 15) step();
    chk("wrapb_pre", 32'(level_b), 32'(1));
    step();
    chk("wrapb_mark", 32'(level_b), 32'(2));
    while ((cyc % 16) != 15) step();
    chk("wrapb_16", 32'(level_b), 32'(2));
    soi_b = 8'h3D;
    step();
    step();
    chk("wrapb_merge", 32'(level_b), 32'(3));
    rdy_b = 1'b1;
    chk("wrapb_e0", 32'(data_b), 32'(eb(1'b0, 4'h3, 8'h3C)));
    step();
    chk("wrapb_e1", 32'(data_b), 32'(eb(1'b1, 4'hF, 8'h3C)));
    step();
    chk("wrapb_e2", 32'(data_b), 32'(eb(1'b1, 4'hF, 8'h3D)));
    step();
    chk("wrapb_empty", 32'(level_b), 32'(0));
    rdy_b = 1'b0;

    // asynchronous reset with entries buffered and the reader mid-handshake
    for (int i = 0; i < 5; i++) begin
      soi_a = 8'h50 + 8'(i);
      step();
    end
    chk("pre_rst_level", 32'(level_a), 32'(5));
    rdy_a = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_a), 32'(0));
    chk("arst_level", 32'(level_a), 32'(0));
    chk("arst_data", 32'(data_a), 32'(0));
    chk("arst_drop", 32'(drop_a), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    rdy_a = 1'b0;
    soi_a = 8'h77;
    step();
    chk("post_rst_level", 32'(level_a), 32'(1));
    chk("post_rst_sync", 32'(data_a), 32'(ea(1'b0, 16'd0, 8'h77)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
